// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
// Access modes and byte-strobe expansion used by the top level and the bench.
package reg_file_pkg;

    typedef enum logic [1:0] {RW, RO, W1C, PULSE} access_mode_t;

    // Widest register supported by strb_to_mask; callers truncate to their width.
    localparam int MAX_W  = 1024;
    localparam int MAX_SW = MAX_W / 8;

    function automatic logic [MAX_W-1:0] strb_to_mask(input logic [MAX_SW-1:0] strb);
        logic [MAX_W-1:0] m;
        m = '0;
        for (int b = 0; b < MAX_SW; b++) m[b*8 +: 8] = {8{strb[b]}};
        return m;
    endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One registered read port: samples the flat register array on read_en,
// returning 0 for addresses beyond the populated registers.
module reg_file_read_port #(
    parameter int REGISTER_WIDTH = 32,
    parameter int NUM_REGISTERS  = 16,
    parameter int AW             = $clog2(NUM_REGISTERS)
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0] regs_i,
    input  logic                                         en_i,
    input  logic [AW-1:0]                                addr_i,
    output logic [REGISTER_WIDTH-1:0]                    data_o,
    output logic                                         valid_o
);

    logic [REGISTER_WIDTH-1:0] sel;
    logic [REGISTER_WIDTH-1:0] data_q;
    logic                      valid_q;

    // A fully populated address space has no out-of-range encodings to filter.
    if (NUM_REGISTERS == (1 << AW)) begin : g_full
        assign sel = regs_i[addr_i];
    end else begin : g_part
        assign sel = (addr_i < AW'(NUM_REGISTERS)) ? regs_i[addr_i] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= en_i;
            if (en_i) data_q <= sel;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/reg_file_memory_mp.sv
// CSR file with one byte-strobed bus write port, NUM_READ_PORTS registered
// read ports and per-register access modes (RW / RO / W1C / PULSE).
module reg_file_memory_mp
    import reg_file_pkg::*;
#(
    parameter int REGISTER_WIDTH = 32,
    parameter int NUM_REGISTERS  = 16,
    parameter int NUM_READ_PORTS = 2,
    parameter int AW             = $clog2(NUM_REGISTERS),
    parameter logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0] RESET_VALUES = '0,
    // Each entry is an access_mode_t encoding.
    parameter logic [NUM_REGISTERS-1:0][1:0] ACCESS_MODES = '0
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [REGISTER_WIDTH-1:0]                     write_data,
    input  logic [REGISTER_WIDTH/8-1:0]                   write_strb,
    input  logic [AW-1:0]                                 write_addr,
    input  logic                                          write_en,
    output logic                                          write_ack,
    input  logic [NUM_READ_PORTS-1:0]                     read_en,
    input  logic [NUM_READ_PORTS-1:0][AW-1:0]             read_addr,
    output logic [NUM_READ_PORTS-1:0][REGISTER_WIDTH-1:0] read_data,
    output logic [NUM_READ_PORTS-1:0]                     read_valid,
    input  logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0]  hw_data,
    input  logic [NUM_REGISTERS-1:0]                      hw_set,
    output logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0]  reg_out
);

    if (REGISTER_WIDTH % 8 != 0 || REGISTER_WIDTH > MAX_W) begin : g_bad_width
        $error("REGISTER_WIDTH must be a multiple of 8 and at most %0d", MAX_W);
    end
    if (NUM_REGISTERS < 2 || NUM_READ_PORTS < 1) begin : g_bad_count
        $error("NUM_REGISTERS must be >= 2 and NUM_READ_PORTS >= 1");
    end

    logic [REGISTER_WIDTH-1:0] wr_mask;
    logic                      write_ack_q;

    assign wr_mask = REGISTER_WIDTH'(strb_to_mask(MAX_SW'(write_strb)));

    for (genvar i = 0; i < NUM_REGISTERS; i++) begin : g_reg
        localparam logic [AW-1:0] IDX = AW'(i);
        logic [REGISTER_WIDTH-1:0] reg_q, reg_d, hit_mask;

        assign hit_mask = (write_en && write_addr == IDX) ? wr_mask : '0;

        always_comb begin
            reg_d = reg_q;
            case (access_mode_t'(ACCESS_MODES[i]))
                RW:    reg_d = (reg_q & ~hit_mask) | (write_data & hit_mask);
                RO:    reg_d = hw_data[i];
                // Set is OR-ed last so a simultaneous hardware set beats the clear.
                W1C:   reg_d = (reg_q & ~(write_data & hit_mask))
                             | (hw_set[i] ? hw_data[i] : '0);
                PULSE: reg_d = write_data & hit_mask;
                default: reg_d = reg_q;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) reg_q <= RESET_VALUES[i];
            else     reg_q <= reg_d;
        end

        assign reg_out[i] = reg_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) write_ack_q <= 1'b0;
        else     write_ack_q <= write_en;
    end

    assign write_ack = write_ack_q;

    // Read ports sample reg_out before this edge's update, giving read-first behaviour.
    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rport
        reg_file_read_port #(
            .REGISTER_WIDTH(REGISTER_WIDTH),
            .NUM_REGISTERS (NUM_REGISTERS),
            .AW            (AW)
        ) u_rport (
            .clk    (clk),
            .rst    (rst),
            .regs_i (reg_out),
            .en_i   (read_en[p]),
            .addr_i (read_addr[p]),
            .data_o (read_data[p]),
            .valid_o(read_valid[p])
        );
    end

endmodule

// File: tb/tb_reg_file_memory_mp.sv
// Randomized and directed bench for reg_file_memory_mp against a per-byte
// behavioural model of the register file.
module tb_reg_file_memory_mp;
    import reg_file_pkg::*;

    localparam int W  = 32;
    localparam int N  = 12;
    localparam int P  = 2;
    localparam int AW = 4;

    localparam logic [N-1:0][W-1:0] RV = {
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
        32'h0000000F, 32'h00000010, 32'hDEADBEEF, 32'h0000ABCD, 32'h0, 32'h11223344};
    localparam logic [N-1:0][1:0] AM = {
        2'd0, 2'd3, 2'd2, 2'd0, 2'd3, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [W-1:0]              write_data;
    logic [W/8-1:0]            write_strb;
    logic [AW-1:0]             write_addr;
    logic                      write_en;
    logic                      write_ack;
    logic [P-1:0]              read_en;
    logic [P-1:0][AW-1:0]      read_addr;
    logic [P-1:0][W-1:0]       read_data;
    logic [P-1:0]              read_valid;
    logic [N-1:0][W-1:0]       hw_data;
    logic [N-1:0]              hw_set;
    logic [N-1:0][W-1:0]       reg_out;

    reg_file_memory_mp #(
        .REGISTER_WIDTH(W), .NUM_REGISTERS(N), .NUM_READ_PORTS(P), .AW(AW),
        .RESET_VALUES(RV), .ACCESS_MODES(AM)
    ) dut (
        .clk(clk), .rst(rst),
        .write_data(write_data), .write_strb(write_strb), .write_addr(write_addr),
        .write_en(write_en), .write_ack(write_ack),
        .read_en(read_en), .read_addr(read_addr), .read_data(read_data),
        .read_valid(read_valid), .hw_data(hw_data), .hw_set(hw_set), .reg_out(reg_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [W-1:0] m      [N];
    logic [W-1:0] nm     [N];
    logic [W-1:0] e_rd   [P];
    logic [W-1:0] n_rd   [P];
    logic         e_rv   [P];
    logic         n_rv   [P];
    logic         e_ack, n_ack;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m[i] = RV[i];
        for (int p = 0; p < P; p++) begin e_rd[p] = '0; e_rv[p] = 1'b0; end
        e_ack = 1'b0;
    endtask

    // Next state from the current inputs, byte by byte.
    task automatic model_next();
        for (int i = 0; i < N; i++) begin
            bit hit;
            hit   = write_en && (int'(write_addr) == i);
            nm[i] = m[i];
            case (access_mode_t'(AM[i]))
                RO:    nm[i] = hw_data[i];
                PULSE: begin
                    nm[i] = '0;
                    for (int b = 0; b < W/8; b++)
                        if (hit && write_strb[b]) nm[i][8*b +: 8] = write_data[8*b +: 8];
                end
                W1C: begin
                    for (int b = 0; b < W/8; b++)
                        if (hit && write_strb[b]) nm[i][8*b +: 8] = m[i][8*b +: 8] & ~write_data[8*b +: 8];
                    if (hw_set[i]) nm[i] = nm[i] | hw_data[i];
                end
                default: begin
                    for (int b = 0; b < W/8; b++)
                        if (hit && write_strb[b]) nm[i][8*b +: 8] = write_data[8*b +: 8];
                end
            endcase
        end
        for (int p = 0; p < P; p++) begin
            n_rv[p] = read_en[p];
            n_rd[p] = e_rd[p];
            if (read_en[p]) n_rd[p] = (int'(read_addr[p]) < N) ? m[read_addr[p]] : '0;
        end
        n_ack = write_en;
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        for (int i = 0; i < N; i++) m[i] = nm[i];
        for (int p = 0; p < P; p++) begin e_rd[p] = n_rd[p]; e_rv[p] = n_rv[p]; end
        e_ack = n_ack;
        #1;
    endtask

    task automatic idle();
        write_data = '0; write_strb = '0; write_addr = '0; write_en = 1'b0;
        read_en = '0; read_addr = '0; hw_data = '0; hw_set = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W/8-1:0] s);
        write_en = 1'b1; write_addr = a; write_data = d; write_strb = s;
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            for (int i = 0; i < N; i++) check($sformatf("reg_out[%0d]", i), reg_out[i], m[i]);
            for (int p = 0; p < P; p++) begin
                check($sformatf("read_data[%0d]", p), read_data[p], e_rd[p]);
                check($sformatf("read_valid[%0d]", p), W'(read_valid[p]), W'(e_rv[p]));
            end
            check("write_ack", W'(write_ack), W'(e_ack));
        end
    end

    initial begin
        idle();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) check($sformatf("rst reg_out[%0d]", i), reg_out[i], RV[i]);
        check("rst read_valid", W'(read_valid), '0);
        check("rst read_data0", read_data[0], '0);
        check("rst write_ack", W'(write_ack), '0);
        #2 rst = 1'b0;
        chk_en = 1'b1;

        // Reset value through a read port
        idle(); read_en = 2'b01; read_addr[0] = 4'd3; step();
        @(negedge clk);
        check("lit rd reset", read_data[0], 32'hDEADBEEF);
        check("lit rv reset", W'(read_valid[0]), 32'd1);

        // Byte strobes on RW
        idle(); wr(4'd0, 32'hAABBCCDD, 4'b0101); step();
        @(negedge clk);
        check("lit strobe", reg_out[0], 32'h11BB33DD);
        check("lit strobe model", m[0], 32'h11BB33DD);
        check("lit strobe ack", W'(write_ack), 32'd1);

        // W1C clear with concurrent hardware set
        idle(); wr(4'd5, 32'h3, 4'hF); hw_set[5] = 1'b1; hw_data[5] = 32'h1; step();
        @(negedge clk);
        check("lit w1c", reg_out[5], 32'h0000000D);

        // RO ignores bus writes and follows hw_data
        idle(); wr(4'd2, 32'hFFFFFFFF, 4'hF); hw_data[2] = 32'h5A; step();
        @(negedge clk);
        check("lit ro", reg_out[2], 32'h5A);
        check("lit ro ack", W'(write_ack), 32'd1);
        idle(); hw_data[2] = 32'h5A; read_en = 2'b01; read_addr[0] = 4'd2; step();
        @(negedge clk);
        check("lit ro read", read_data[0], 32'h5A);

        // PULSE lasts one cycle
        idle(); wr(4'd7, 32'h1, 4'hF); step();
        @(negedge clk);
        check("lit pulse hi", reg_out[7], 32'h1);
        idle(); step();
        @(negedge clk);
        check("lit pulse lo", reg_out[7], 32'h0);

        // Read-during-write on both ports is read-first
        idle(); wr(4'd4, 32'h99, 4'hF); read_en = 2'b11; read_addr[0] = 4'd4; read_addr[1] = 4'd4; step();
        @(negedge clk);
        check("lit rdw p0", read_data[0], 32'h10);
        check("lit rdw p1", read_data[1], 32'h10);
        idle(); read_en = 2'b01; read_addr[0] = 4'd4; step();
        @(negedge clk);
        check("lit rdw next", read_data[0], 32'h99);

        // Out-of-range write and read
        idle(); wr(4'd13, 32'hFFFFFFFF, 4'hF); read_en = 2'b10; read_addr[1] = 4'd13; step();
        @(negedge clk);
        check("lit oor rd", read_data[1], 32'h0);
        check("lit oor rv", W'(read_valid[1]), 32'd1);
        check("lit oor ack", W'(write_ack), 32'd1);
        check("lit oor reg0", reg_out[0], 32'h11BB33DD);

        // Reset during the ack/valid cycle
        idle(); wr(4'd1, 32'h5, 4'hF); read_en = 2'b11; read_addr[0] = 4'd3; read_addr[1] = 4'd4; step();
        idle();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("lit midrst ack", W'(write_ack), 32'd0);
        check("lit midrst rv", W'(read_valid), 32'd0);
        check("lit midrst rd0", read_data[0], 32'd0);
        check("lit midrst reg1", reg_out[1], 32'd0);
        model_reset();
        @(negedge clk);
        #2 rst = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            write_en   = 1'($urandom);
            write_addr = AW'($urandom);
            write_data = $urandom;
            write_strb = (W/8)'($urandom);
            read_en    = P'($urandom);
            for (int p = 0; p < P; p++) read_addr[p] = AW'($urandom);
            for (int i = 0; i < N; i++) hw_data[i] = $urandom;
            hw_set = N'($urandom) & N'($urandom);
            step();
        end
        idle();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
